// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-access master: FSM states, frame slot
// indices and the default SCL half-period.
package i2c_pkg;

    localparam int HALF_PERIOD_DEFAULT = 125;

    typedef enum logic [2:0] {
        IDLE,
        START_C,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        STOP_HIGH,
        DONE
    } i2c_state_e;

    localparam logic [1:0] SLOT_ADDR = 2'd0;
    localparam logic [1:0] SLOT_REG  = 2'd1;
    localparam logic [1:0] SLOT_DATA = 2'd2;

endpackage

// File: rtl/i2c_half_timer.sv
// SCL half-period timer: restarts on clear, flags the middle and the last cycle
// of each half-period while enabled.
module i2c_half_timer
    import i2c_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic half_done,
    output logic mid_point
);

    localparam int            CW   = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] MID  = CW'(HALF_PERIOD / 2);
    localparam logic [CW-1:0] CAP  = CW'(HALF_PERIOD);

    logic [CW-1:0] cnt;

    // Saturates at HALF_PERIOD so the one-cycle stop release never wraps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CAP)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign half_done = enable && (cnt == LAST);
    assign mid_point = enable && (cnt == MID);

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master issuing one register write or read per command:
// START, {DevID,RW}+ACK, RegAddr+ACK, data+ACK/NACK, STOP.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic       RW,
    input  logic [6:0] DevID,
    input  logic [7:0] RegAddr,
    input  logic [7:0] WrData,
    input  logic       iSDA,
    output logic       SCL,
    output logic       oSDA,
    output logic [7:0] RdData,
    output logic       Busy,
    output logic       Done,
    output logic       AckErr,
    output i2c_state_e dbg_state
);

    i2c_state_e state, next_state;

    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wr_q;
    logic [1:0] slot_q;
    logic [2:0] bit_q;
    logic       ack_q;
    logic       stop_rel_q;
    logic [6:0] rx_q;

    logic       half_done;
    logic       mid_point;
    logic       accept;
    logic       read_slot;
    logic       sample;
    logic       ack_fail;
    logic       bit_advance;
    logic [7:0] cur_byte;

    i2c_half_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (Reset),
        .clear    (next_state != state),
        .enable   (Busy),
        .half_done(half_done),
        .mid_point(mid_point)
    );

    assign accept      = Start && ((state == IDLE) || (state == DONE));
    assign read_slot   = rw_q && (slot_q == SLOT_DATA);
    assign sample      = (state == BIT_HIGH) && mid_point;
    // The read data slot ends on the master's own NACK, so it is never an error.
    assign ack_fail    = sample && ack_q && !read_slot && iSDA;
    assign bit_advance = (state == BIT_HIGH) && half_done && (next_state == BIT_LOW);
    assign dbg_state   = state;

    always_comb begin
        cur_byte = wr_q;
        case (slot_q)
            SLOT_ADDR: cur_byte = {dev_q, rw_q};
            SLOT_REG:  cur_byte = reg_q;
            default:   cur_byte = wr_q;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        SCL        = 1'b1;
        oSDA       = 1'b1;
        Busy       = 1'b1;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (accept) next_state = START_C;
            end
            START_C: begin
                oSDA = 1'b0;
                if (half_done) next_state = BIT_LOW;
            end
            BIT_LOW: begin
                SCL  = 1'b0;
                oSDA = (ack_q || read_slot) ? 1'b1 : cur_byte[bit_q];
                if (half_done) next_state = BIT_HIGH;
            end
            BIT_HIGH: begin
                oSDA = (ack_q || read_slot) ? 1'b1 : cur_byte[bit_q];
                if (half_done) begin
                    if (ack_q && (AckErr || ack_fail || (slot_q == SLOT_DATA))) begin
                        next_state = STOP_LOW;
                    end else begin
                        next_state = BIT_LOW;
                    end
                end
            end
            STOP_LOW: begin
                SCL  = 1'b0;
                oSDA = 1'b0;
                if (half_done) next_state = STOP_HIGH;
            end
            STOP_HIGH: begin
                // SDA rises for one cycle with SCL high: the STOP condition.
                oSDA = stop_rel_q;
                if (stop_rel_q) next_state = DONE;
            end
            DONE: begin
                Busy       = 1'b0;
                Done       = 1'b1;
                next_state = accept ? START_C : IDLE;
            end
            default: begin
                Busy       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rw_q       <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            wr_q       <= '0;
            slot_q     <= SLOT_ADDR;
            bit_q      <= 3'd7;
            ack_q      <= 1'b0;
            stop_rel_q <= 1'b0;
            rx_q       <= '0;
            RdData     <= 8'h00;
            AckErr     <= 1'b0;
        end else begin
            stop_rel_q <= (state == STOP_HIGH) && half_done;
            if (accept) begin
                rw_q   <= RW;
                dev_q  <= DevID;
                reg_q  <= RegAddr;
                wr_q   <= WrData;
                slot_q <= SLOT_ADDR;
                bit_q  <= 3'd7;
                ack_q  <= 1'b0;
                AckErr <= 1'b0;
            end else if (bit_advance) begin
                if (ack_q) begin
                    ack_q  <= 1'b0;
                    bit_q  <= 3'd7;
                    slot_q <= (slot_q == SLOT_DATA) ? SLOT_DATA : slot_q + 2'd1;
                end else if (bit_q == 3'd0) begin
                    ack_q <= 1'b1;
                end else begin
                    bit_q <= bit_q - 3'd1;
                end
            end
            if (ack_fail) begin
                AckErr <= 1'b1;
            end
            if (sample && !ack_q && read_slot) begin
                rx_q <= {rx_q[5:0], iSDA};
                if (bit_q == 3'd0) begin
                    RdData <= {rx_q, iSDA};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a bus-level slave model answers each frame while
// directed and random commands are checked against expected bytes and timing.
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    localparam int HP    = 4;
    localparam int LIMIT = 2000;

    typedef struct {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] wr;
        logic [7:0] rd_data;
        int         nack_slot;
        bit         poke;
        logic       exp_err;
        int         exp_slots;
        logic [7:0] exp_rd;
    } txn_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       rw;
    logic [6:0] dev_id;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       isda;
    logic       scl;
    logic       osda;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    i2c_state_e dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [7:0] rd_model;

    logic       cfg_rw;
    int         cfg_nack;
    logic [7:0] cfg_data;
    logic       prev_scl;
    logic       prev_sda;
    logic       in_frame;
    int         rise_cnt;
    int         frame_bits;
    int         stop_cnt;
    logic       cap[0:31];

    i2c_master_ctrl #(
        .HALF_PERIOD(HP)
    ) dut (
        .CLK      (clk),
        .Reset    (reset_n),
        .Start    (start),
        .RW       (rw),
        .DevID    (dev_id),
        .RegAddr  (reg_addr),
        .WrData   (wr_data),
        .iSDA     (isda),
        .SCL      (scl),
        .oSDA     (osda),
        .RdData   (rd_data),
        .Busy     (busy),
        .Done     (done),
        .AckErr   (ack_err),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Slave answer for frame bit k (1-based): ACK low, read data MSB first.
    function automatic logic slave_bit(input int k);
        int s;
        int pos;
        s   = (k - 1) / 9;
        pos = (k - 1) % 9;
        if (s > cfg_nack) return 1'b1;
        if (pos == 8) return ((s == cfg_nack) || (s == 2 && cfg_rw)) ? 1'b1 : 1'b0;
        if (s == 2 && cfg_rw) return cfg_data[7 - pos];
        return 1'b1;
    endfunction

    // Bus monitor and slave, sampling away from the active edge.
    initial begin
        prev_scl   = 1'b1;
        prev_sda   = 1'b1;
        in_frame   = 1'b0;
        rise_cnt   = 0;
        frame_bits = 0;
        stop_cnt   = 0;
        isda       = 1'b1;
        forever begin
            @(negedge clk);
            if (scl && prev_scl && prev_sda && !osda) begin
                rise_cnt = 0;
                in_frame = 1'b1;
            end else if (scl && prev_scl && !prev_sda && osda) begin
                if (in_frame) begin
                    stop_cnt++;
                    frame_bits = rise_cnt - 1;
                end
                in_frame = 1'b0;
            end else if (scl && !prev_scl) begin
                rise_cnt++;
                if (rise_cnt < 32) cap[rise_cnt] = osda;
            end else if (!scl && prev_scl) begin
                isda = slave_bit(rise_cnt + 1);
            end
            prev_scl = scl;
            prev_sda = osda;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic r, input logic [6:0] d, input logic [7:0] ra,
                                input logic [7:0] w, input logic [7:0] rdd, input int nk,
                                input bit pk, input logic ee, input int es, input logic [7:0] er);
        txn_t t;
        t.rw = r; t.dev = d; t.reg_addr = ra; t.wr = w; t.rd_data = rdd;
        t.nack_slot = nk; t.poke = pk; t.exp_err = ee; t.exp_slots = es; t.exp_rd = er;
        return t;
    endfunction

    // Reference: the first slave-acknowledged slot that the slave refuses ends the frame.
    function automatic txn_t predict(input txn_t t, input logic [7:0] rd_prev);
        int fail;
        fail = -1;
        for (int s = 0; s < 3; s++) begin
            if (fail < 0 && !(s == 2 && t.rw) && s >= t.nack_slot) fail = s;
        end
        t.exp_err   = (fail >= 0);
        t.exp_slots = (fail >= 0) ? fail + 1 : 3;
        t.exp_rd    = (t.rw && t.exp_slots == 3) ? t.rd_data : rd_prev;
        return t;
    endfunction

    task automatic drive_cmd(input txn_t t);
        rw       = t.rw;
        dev_id   = t.dev;
        reg_addr = t.reg_addr;
        wr_data  = t.wr;
        start    = 1'b1;
    endtask

    task automatic run_txn(input txn_t t, input bit chained_in, input bit chain_out, input txn_t nt);
        int         n;
        int         stops0;
        bit         seen;
        logic       ae;
        logic       bz;
        logic [7:0] rd;
        logic [8:0] got;
        logic [8:0] exp;
        int         s;
        if (t.exp_slots >= 1) exp_q.push_back({t.dev, t.rw, 1'b1});
        if (t.exp_slots >= 2) exp_q.push_back({t.reg_addr, 1'b1});
        if (t.exp_slots >= 3) exp_q.push_back(t.rw ? 9'h1FF : {t.wr, 1'b1});
        cfg_rw   = t.rw;
        cfg_nack = t.nack_slot;
        cfg_data = t.rd_data;
        stops0   = stop_cnt;
        if (!chained_in) begin
            @(negedge clk);
            drive_cmd(t);
            @(posedge clk);
        end
        n = 0; seen = 0; ae = 1'bx; bz = 1'bx; rd = 'x;
        while (!seen && n < LIMIT) begin
            @(negedge clk);
            if (n == 0) begin
                start    = 1'b0;
                rw       = 1'($urandom_range(0, 1));
                dev_id   = 7'($urandom);
                reg_addr = 8'($urandom);
                wr_data  = 8'($urandom);
                check("busy_after_accept", busy, 1);
                check("state_after_accept", dbg_state, START_C);
                check("ack_err_clear", ack_err, 0);
            end
            if (t.poke && n == 20) start = 1'b1;
            if (t.poke && n == 21) start = 1'b0;
            if (done) begin
                seen = 1; ae = ack_err; rd = rd_data; bz = busy;
                if (chain_out) drive_cmd(nt);
            end
            @(posedge clk);
            n++;
        end
        check("done_latency", n, (3 + 18 * t.exp_slots) * HP + 2);
        check("busy_in_done", bz, 0);
        check("ack_err", ae, t.exp_err);
        check("rd_data", rd, t.exp_rd);
        check("stop_count", stop_cnt - stops0, 1);
        check("frame_bits", frame_bits, 9 * t.exp_slots);
        s = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = '0;
            for (int i = 0; i < 9; i++) got = {got[7:0], cap[9 * s + 1 + i]};
            check($sformatf("slot%0d_bits", s), got, exp);
            s++;
        end
        if (!chain_out) begin
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("idle_after_done", dbg_state, IDLE);
            check("ack_err_hold", ack_err, t.exp_err);
        end
    endtask

    txn_t tbl[10];
    txn_t ta;
    txn_t tb;
    txn_t tc;
    bit   found;

    initial begin
        reset_n = 1'b1; start = 1'b0; rw = 1'b0; dev_id = '0; reg_addr = '0; wr_data = '0;
        rd_model = 8'h00;
        //               rw  dev    reg    wr     rdata  nk poke err slots rd
        tbl[0] = mk(1'b0, 7'h05, 8'h12, 8'hA5, 8'h00, 3, 0, 1'b0, 3, 8'h00);
        tbl[1] = mk(1'b1, 7'h05, 8'h03, 8'h00, 8'hF0, 3, 0, 1'b0, 3, 8'hF0);
        tbl[2] = mk(1'b0, 7'h06, 8'h44, 8'h11, 8'h00, 0, 0, 1'b1, 1, 8'hF0);
        tbl[3] = mk(1'b0, 7'h2A, 8'h80, 8'h5A, 8'h00, 1, 0, 1'b1, 2, 8'hF0);
        tbl[4] = mk(1'b0, 7'h11, 8'h01, 8'hFF, 8'h00, 2, 0, 1'b1, 3, 8'hF0);
        tbl[5] = mk(1'b1, 7'h33, 8'h7E, 8'h00, 8'h3C, 2, 0, 1'b0, 3, 8'h3C);
        tbl[6] = mk(1'b1, 7'h06, 8'h10, 8'h00, 8'h99, 0, 0, 1'b1, 1, 8'h3C);
        tbl[7] = mk(1'b0, 7'h05, 8'h12, 8'hC3, 8'h00, 3, 1, 1'b0, 3, 8'h3C);
        tbl[8] = mk(1'b1, 7'h7F, 8'hFF, 8'h00, 8'h00, 3, 0, 1'b0, 3, 8'h00);
        tbl[9] = mk(1'b1, 7'h01, 8'h02, 8'h00, 8'h5A, 1, 0, 1'b1, 2, 8'h00);

        // Asynchronous reset before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("rst_scl", scl, 1);
        check("rst_osda", osda, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_state", dbg_state, IDLE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold_busy", busy, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], 0, 0, tbl[i]);
            rd_model = tbl[i].exp_rd;
        end

        // Back-to-back: second command raised during the DONE cycle.
        ta = predict(mk(1'b0, 7'h09, 8'h34, 8'h5E, 8'h00, 3, 0, 0, 0, 0), rd_model);
        rd_model = ta.exp_rd;
        tb = predict(mk(1'b1, 7'h0C, 8'h56, 8'h00, 8'hB7, 3, 0, 0, 0, 0), rd_model);
        run_txn(ta, 0, 1, tb);
        run_txn(tb, 1, 0, tb);
        rd_model = tb.exp_rd;

        // Reset during a slot1 BIT_LOW, then a write right after release.
        @(negedge clk);
        cfg_rw = 1'b0; cfg_nack = 3; cfg_data = 8'h00;
        drive_cmd(mk(1'b0, 7'h15, 8'h22, 8'h66, 8'h00, 3, 0, 0, 0, 0));
        @(posedge clk);
        #1 start = 1'b0;
        found = 0;
        for (int i = 0; i < LIMIT && !found; i++) begin
            @(negedge clk);
            if (rise_cnt == 11 && !scl && dbg_state == BIT_LOW) found = 1;
        end
        check("reset_wait_slot1", found, 1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_scl", scl, 1);
        check("midrst_osda", osda, 1);
        check("midrst_busy", busy, 0);
        check("midrst_state", dbg_state, IDLE);
        check("midrst_rd_data", rd_data, 8'h00);
        rd_model = 8'h00;
        tc = predict(mk(1'b0, 7'h2C, 8'h9D, 8'h4B, 8'h00, 3, 0, 0, 0, 0), rd_model);
        @(negedge clk);
        reset_n = 1'b1;
        cfg_rw = tc.rw; cfg_nack = tc.nack_slot; cfg_data = tc.rd_data;
        drive_cmd(tc);
        @(posedge clk);
        run_txn(tc, 1, 0, tc);
        rd_model = tc.exp_rd;

        // Random commands against the reference model.
        for (int i = 0; i < 20; i++) begin
            int r;
            r  = $urandom_range(0, 5);
            tc = mk(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), (r < 3) ? r : 3, ($urandom_range(0, 3) == 0), 0, 0, 0);
            tc = predict(tc, rd_model);
            run_txn(tc, 0, 0, tc);
            rd_model = tc.exp_rd;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
